// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StHalt    = 2'd2
   } pipe_state_e;

   // EX operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Bit positions of the 8-bit pipeline control word
   localparam int unsigned CW_REG_WRITE  = 0;
   localparam int unsigned CW_MEM_READ   = 1;
   localparam int unsigned CW_MEM_WRITE  = 2;
   localparam int unsigned CW_BRANCH     = 3;
   localparam int unsigned CW_JUMP       = 4;
   localparam int unsigned CW_ALU_SRC    = 5;
   localparam int unsigned CW_MEM_TO_REG = 6;
   localparam int unsigned CW_VALID      = 7;

   localparam logic [7:0] CW_NOP = 8'h00;

   // A flushed stage register loads the NOP word: no side effects downstream
   function automatic logic [7:0] flush_cw(input logic [7:0] cw, input logic flush);
      return flush ? CW_NOP : cw;
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// EX-stage operand forwarding select for one source register.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_reg_write,
   input  logic [4:0] i_wb_rd,
   input  logic       i_wb_reg_write,
   output logic [1:0] o_fwd
);

   // MEM holds the younger result, so it wins over WB; x0 is never forwarded
   always_comb begin
      o_fwd = FWD_RF;
      if (i_mem_reg_write && (i_mem_rd != 5'd0) && (i_mem_rd == i_rs)) begin
         o_fwd = FWD_MEM;
      end else if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs)) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enables, flushes and forwarding selects for the 5-stage core.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic [4:0]       i_ex_rs1,
   input  logic [4:0]       i_ex_rs2,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_mem_read,
   input  logic             i_ex_branch_taken,
   input  logic [4:0]       i_mem_rd,
   input  logic             i_mem_reg_write,
   input  logic [4:0]       i_wb_rd,
   input  logic             i_wb_reg_write,
   input  logic             i_mem_req,
   input  logic             i_mem_ready,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_id_ex_en,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_flush,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cycles
);

   localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   pipe_state_e      r_state, w_state_d;
   logic [WaitW-1:0] r_wait_cnt, w_wait_d;
   logic             r_mem_err, w_mem_err_d;
   logic [CNT_W-1:0] r_stall_cycles;

   logic       w_lu, w_mw, w_freeze, w_squash, w_bubble;
   logic [1:0] w_fwd_a, w_fwd_b;

   assign w_lu = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                 ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
   assign w_mw = i_mem_req && !i_mem_ready;

   // Next-state and hazard decode; branch squash outranks the load-use bubble
   always_comb begin
      w_state_d   = r_state;
      w_wait_d    = r_wait_cnt;
      w_mem_err_d = r_mem_err;
      w_freeze    = 1'b0;
      w_squash    = 1'b0;
      w_bubble    = 1'b0;
      unique case (r_state)
         StRun: begin
            if (w_mw) begin
               w_freeze  = 1'b1;
               w_state_d = StMemWait;
               w_wait_d  = WaitW'(1);
            end else begin
               w_squash = i_ex_branch_taken;
               w_bubble = !i_ex_branch_taken && w_lu;
            end
         end
         StMemWait: begin
            // A dropped request releases the freeze just like ready does
            if (i_mem_ready || !i_mem_req) begin
               w_state_d = StRun;
               w_wait_d  = '0;
               w_squash  = i_ex_branch_taken;
               w_bubble  = !i_ex_branch_taken && w_lu;
            end else begin
               w_freeze = 1'b1;
               if (r_wait_cnt == WaitLast) begin
                  w_state_d   = StHalt;
                  w_mem_err_d = 1'b1;
               end else begin
                  w_wait_d = r_wait_cnt + WaitW'(1);
               end
            end
         end
         StHalt: begin
            w_freeze = 1'b1;
         end
         default: begin
            w_state_d = StRun;
            w_wait_d  = '0;
         end
      endcase
   end

   // Output decode; reset forces everything off and both flushes on
   always_comb begin
      o_pc_en       = rst_n && !w_freeze && !w_bubble;
      o_if_id_en    = rst_n && !w_freeze && !w_bubble;
      o_id_ex_en    = rst_n && !w_freeze;
      o_ex_mem_en   = rst_n && !w_freeze;
      o_mem_wb_en   = rst_n && !w_freeze;
      o_if_id_flush = !rst_n || w_squash;
      o_id_ex_flush = !rst_n || w_squash || w_bubble;
      o_fwd_a       = rst_n ? w_fwd_a : FWD_RF;
      o_fwd_b       = rst_n ? w_fwd_b : FWD_RF;
   end

   // FSM state, wait counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StRun;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_wait_cnt <= w_wait_d;
         r_mem_err  <= w_mem_err_d;
      end
   end

   // Performance counter of cycles where the PC did not advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (!o_pc_en) begin
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign o_mem_err      = r_mem_err;
   assign o_stall_cycles = r_stall_cycles;

   fwd_sel u_fwd_a (
      .i_rs           (i_ex_rs1),
      .i_mem_rd       (i_mem_rd),
      .i_mem_reg_write(i_mem_reg_write),
      .i_wb_rd        (i_wb_rd),
      .i_wb_reg_write (i_wb_reg_write),
      .o_fwd          (w_fwd_a)
   );

   fwd_sel u_fwd_b (
      .i_rs           (i_ex_rs2),
      .i_mem_rd       (i_mem_rd),
      .i_mem_reg_write(i_mem_reg_write),
      .i_wb_rd        (i_wb_rd),
      .i_wb_reg_write (i_wb_reg_write),
      .o_fwd          (w_fwd_b)
   );

endmodule
